// File: rtl/i2c_arb_pkg.sv
// Shared types and defaults for the I2C master arbiter.
// No logic; constants and typedefs only.
// No flow control of its own.
package i2c_arb_pkg;

   localparam int ADDR_WIDTH_DEF     = 7;
   localparam int DATA_WIDTH_DEF     = 8;
   localparam int TIMEOUT_CYCLES_DEF = 4096;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_DONE = 2'd2,
      RESP      = 2'd3
   } arb_state_e;

   // Plain-vector aliases so state registers stay legacy-tool friendly
   localparam logic [1:0] ST_IDLE      = IDLE;
   localparam logic [1:0] ST_ISSUE     = ISSUE;
   localparam logic [1:0] ST_WAIT_DONE = WAIT_DONE;
   localparam logic [1:0] ST_RESP      = RESP;

   // Command as seen by the master at the default widths
   typedef struct packed {
      logic                      rw;
      logic [ADDR_WIDTH_DEF-1:0] addr;
      logic [DATA_WIDTH_DEF-1:0] wdata;
   } i2c_cmd_t;

endpackage

// File: rtl/i2c_master_arbiter_rr_arbiter.sv
// Round-robin pick: first set request at or after ptr, wrapping modulo N.
// Latency: purely combinational.
// Backpressure: none; caller decides whether the grant is used.
module rr_arbiter #(
   parameter  int N  = 4,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx,
   output logic          any
);

   // Scan N slots starting at ptr; the first requester found wins
   always_comb begin
      int          c;
      logic [IW-1:0] c_idx;
      gnt   = '0;
      idx   = '0;
      any   = 1'b0;
      c     = 0;
      c_idx = '0;
      for (int i = 0; i < N; i++) begin
         c     = (int'(ptr) + i) % N;
         c_idx = IW'(c);
         if (!any && req[c_idx]) begin
            gnt[c_idx] = 1'b1;
            idx        = c_idx;
            any        = 1'b1;
         end
      end
   end

endmodule

// File: rtl/i2c_master_arbiter.sv
// Shares one I2C master command port between NUM_REQ requesters, round-robin.
// Latency: accept at T, m_enable from T+1, rsp_valid one cycle after m_ready returns (or timeout).
// Backpressure: req_ready only pulses in IDLE with m_ready high; one command in flight at a time.
module i2c_master_arbiter
   import i2c_arb_pkg::*;
#(
   parameter  int NUM_REQ        = 4,
   parameter  int ADDR_WIDTH     = ADDR_WIDTH_DEF,
   parameter  int DATA_WIDTH     = DATA_WIDTH_DEF,
   parameter  int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
   localparam int IW             = $clog2(NUM_REQ)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [NUM_REQ-1:0]            req_rw,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
   output logic [NUM_REQ-1:0]            rsp_valid,
   output logic [DATA_WIDTH-1:0]         rsp_rdata,
   output logic                          rsp_timeout,
   output logic                          m_enable,
   output logic                          m_rw,
   output logic [ADDR_WIDTH-1:0]         m_address,
   output logic [DATA_WIDTH-1:0]         m_data_in,
   input  logic                          m_ready,
   input  logic [DATA_WIDTH-1:0]         m_data_out,
   output logic                          busy,
   output logic [IW-1:0]                 owner
);

   localparam int            CW      = $clog2(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

   typedef struct packed {
      logic                  rw;
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] wdata;
   } cmd_t;

   logic [1:0]            state_q, state_d;
   logic [IW-1:0]         ptr_q, ptr_d;
   logic [IW-1:0]         owner_q, owner_d;
   cmd_t                  cmd_q, cmd_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  tmo_q, tmo_d;

   logic [NUM_REQ-1:0]    gnt;
   logic [IW-1:0]         gidx;
   logic                  gany;

   rr_arbiter #(.N(NUM_REQ)) u_rr (
      .req (req_valid),
      .ptr (ptr_q),
      .gnt (gnt),
      .idx (gidx),
      .any (gany)
   );

   // Transaction sequencer: grant, drive the master, wait, respond
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      owner_d   = owner_q;
      cmd_d     = cmd_q;
      cnt_d     = cnt_q;
      rdata_d   = rdata_q;
      tmo_d     = tmo_q;
      req_ready = '0;
      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            // A master that is not ready must not see a new command
            if (m_ready && gany && !rst) begin
               req_ready   = gnt;
               owner_d     = gidx;
               cmd_d.rw    = req_rw[gidx];
               cmd_d.addr  = req_addr[gidx*ADDR_WIDTH +: ADDR_WIDTH];
               cmd_d.wdata = req_wdata[gidx*DATA_WIDTH +: DATA_WIDTH];
               tmo_d       = 1'b0;
               state_d     = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            // Master has not picked up the command within the budget
            if (cnt_q == TO_LAST) begin
               tmo_d   = 1'b1;
               rdata_d = '0;
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
               if (!m_ready) state_d = ST_WAIT_DONE;
            end
         end
         ST_WAIT_DONE: begin
            // Completion on the last budget cycle still counts as success
            if (m_ready) begin
               tmo_d   = 1'b0;
               rdata_d = cmd_q.rw ? m_data_out : '0;
               state_d = ST_RESP;
            end else if (cnt_q == TO_LAST) begin
               tmo_d   = 1'b1;
               rdata_d = '0;
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_RESP: begin
            ptr_d   = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State registers; reset abandons any transaction without a response
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         owner_q <= '0;
         cmd_q   <= '0;
         cnt_q   <= '0;
         rdata_q <= '0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         cmd_q   <= cmd_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         tmo_q   <= tmo_d;
      end
   end

   assign busy        = (state_q != ST_IDLE);
   assign owner       = owner_q;
   assign m_enable    = (state_q == ST_ISSUE);
   assign m_rw        = cmd_q.rw;
   assign m_address   = cmd_q.addr;
   assign m_data_in   = cmd_q.wdata;
   assign rsp_valid   = (state_q == ST_RESP) ? (NUM_REQ'(1) << owner_q) : '0;
   assign rsp_rdata   = (state_q == ST_RESP) ? rdata_q : '0;
   assign rsp_timeout = (state_q == ST_RESP) && tmo_q;

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Directed bench for i2c_master_arbiter; second instance has a short timeout.
// Inputs driven and outputs sampled on the falling clock edge.
// Master behaviour is scripted per test through m_ready/m_data_out.
module tb_i2c_master_arbiter;

   localparam int N  = 4;
   localparam int AW = 7;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [N-1:0]  req_valid = '0;
   logic [N-1:0]  req_rw = '0;
   logic [N*AW-1:0] req_addr = '0;
   logic [N*DW-1:0] req_wdata = '0;
   logic          m_ready = 1'b1;
   logic [DW-1:0] m_data_out = '0;

   logic [N-1:0]  req_ready, rsp_valid;
   logic [DW-1:0] rsp_rdata, m_data_in;
   logic          rsp_timeout, m_enable, m_rw, busy;
   logic [AW-1:0] m_address;
   logic [1:0]    owner;

   logic [N-1:0]  t_req_ready, t_rsp_valid;
   logic [DW-1:0] t_rsp_rdata, t_m_data_in;
   logic          t_rsp_timeout, t_m_enable, t_m_rw, t_busy;
   logic [AW-1:0] t_m_address;
   logic [1:0]    t_owner;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   i2c_master_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
      .m_enable(m_enable), .m_rw(m_rw), .m_address(m_address), .m_data_in(m_data_in),
      .m_ready(m_ready), .m_data_out(m_data_out), .busy(busy), .owner(owner)
   );

   i2c_master_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)) dut_to (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(t_req_ready),
      .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(t_rsp_valid), .rsp_rdata(t_rsp_rdata), .rsp_timeout(t_rsp_timeout),
      .m_enable(t_m_enable), .m_rw(t_m_rw), .m_address(t_m_address), .m_data_in(t_m_data_in),
      .m_ready(m_ready), .m_data_out(m_data_out), .busy(t_busy), .owner(t_owner)
   );

   task automatic do_reset();
      rst = 1'b1;
      req_valid = '0;
      m_ready = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req_valid = 4'b1111;
      m_ready = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      total++;
      if ({req_ready, rsp_valid, rsp_rdata, rsp_timeout, m_enable, m_rw, m_address, m_data_in, busy, owner} !== '0) begin
         bad++;
         $display("FAIL reset_outputs: rdy=%b vld=%b en=%b busy=%b owner=%0d addr=%h, required all zero",
                  req_ready, rsp_valid, m_enable, busy, owner, m_address);
      end
      total++;
      if (t_busy !== 1'b0 || t_req_ready !== '0) begin
         bad++;
         $display("FAIL reset_outputs_t: busy=%b rdy=%b, required 0", t_busy, t_req_ready);
      end
      req_valid = '0;
      rst = 1'b0;
   endtask

   task automatic test_write();
      int pulses = 0;
      @(negedge clk);
      req_valid = 4'b0001; req_rw = '0;
      req_addr[0 +: AW] = 7'h50; req_wdata[0 +: DW] = 8'hA5;
      #1;
      total++;
      if (req_ready !== 4'b0001) begin bad++; $display("FAIL write_accept: got %b want 0001", req_ready); end
      @(negedge clk);
      req_valid = '0;
      total++;
      if (m_enable !== 1'b1 || m_address !== 7'h50 || m_data_in !== 8'hA5 || m_rw !== 1'b0 || busy !== 1'b1 || owner !== 2'd0) begin
         bad++;
         $display("FAIL write_issue: en=%b addr=%h din=%h rw=%b busy=%b owner=%0d want 1 50 a5 0 1 0",
                  m_enable, m_address, m_data_in, m_rw, busy, owner);
      end
      @(negedge clk);
      total++;
      if (m_enable !== 1'b1 || m_address !== 7'h50) begin bad++; $display("FAIL write_hold: en=%b addr=%h want 1 50", m_enable, m_address); end
      m_ready = 1'b0;
      @(negedge clk);
      total++;
      if (m_enable !== 1'b0 || busy !== 1'b1 || m_address !== 7'h50) begin
         bad++; $display("FAIL write_wait: en=%b busy=%b addr=%h want 0 1 50", m_enable, busy, m_address);
      end
      repeat (19) begin
         @(negedge clk);
         if (rsp_valid !== '0) pulses++;
      end
      total++;
      if (pulses != 0) begin bad++; $display("FAIL write_early_rsp: got %0d pulses want 0", pulses); end
      m_ready = 1'b1;
      @(negedge clk);
      total++;
      if (rsp_valid !== 4'b0001 || rsp_timeout !== 1'b0 || rsp_rdata !== 8'h00) begin
         bad++; $display("FAIL write_rsp: vld=%b to=%b rdata=%h want 0001 0 00", rsp_valid, rsp_timeout, rsp_rdata);
      end
      @(negedge clk);
      total++;
      if (rsp_valid !== '0 || busy !== 1'b0) begin bad++; $display("FAIL write_single_pulse: vld=%b busy=%b want 0000 0", rsp_valid, busy); end
   endtask

   task automatic test_read();
      req_valid = 4'b0100; req_rw = 4'b0100;
      req_addr[2*AW +: AW] = 7'h3C;
      #1;
      total++;
      if (req_ready !== 4'b0100) begin bad++; $display("FAIL read_accept: got %b want 0100", req_ready); end
      @(negedge clk);
      req_valid = '0;
      total++;
      if (m_enable !== 1'b1 || m_rw !== 1'b1 || m_address !== 7'h3C || owner !== 2'd2) begin
         bad++; $display("FAIL read_issue: en=%b rw=%b addr=%h owner=%0d want 1 1 3c 2", m_enable, m_rw, m_address, owner);
      end
      m_ready = 1'b0;
      @(negedge clk);
      m_data_out = 8'h7E;
      repeat (2) @(negedge clk);
      m_ready = 1'b1;
      @(negedge clk);
      m_data_out = 8'h00;
      total++;
      if (rsp_valid !== 4'b0100 || rsp_rdata !== 8'h7E || rsp_timeout !== 1'b0) begin
         bad++; $display("FAIL read_rsp: vld=%b rdata=%h to=%b want 0100 7e 0", rsp_valid, rsp_rdata, rsp_timeout);
      end
      @(negedge clk);
   endtask

   task automatic test_contention();
      int order[6] = '{0, 1, 2, 3, 0, 2};
      do_reset();
      req_rw = '0;
      @(negedge clk);
      req_valid = 4'b1111;
      for (int k = 0; k < 6; k++) begin
         if (k == 4) req_valid = 4'b0101;
         #1;
         total++;
         if (req_ready !== 4'(1 << order[k])) begin
            bad++; $display("FAIL contention_grant%0d: got %b want requester %0d", k, req_ready, order[k]);
         end
         @(negedge clk);
         req_valid[order[k]] = 1'b0;
         m_ready = 1'b0;
         @(negedge clk);
         m_ready = 1'b1;
         @(negedge clk);
         total++;
         if (rsp_valid !== 4'(1 << order[k])) begin
            bad++; $display("FAIL contention_rsp%0d: got %b want requester %0d", k, rsp_valid, order[k]);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_timeout();
      do_reset();
      req_valid = 4'b0010; req_rw = '0;
      #1;
      total++;
      if (t_req_ready !== 4'b0010) begin bad++; $display("FAIL timeout_accept: got %b want 0010", t_req_ready); end
      @(negedge clk);
      req_valid = '0;
      for (int c = 0; c <= 16; c++) begin
         if (c > 0) @(negedge clk);
         total++;
         if (c < 16) begin
            if (t_m_enable !== 1'b1 || t_rsp_valid !== '0) begin
               bad++; $display("FAIL timeout_wait c=%0d: en=%b vld=%b want 1 0000", c, t_m_enable, t_rsp_valid);
            end
         end else begin
            if (t_rsp_valid !== 4'b0010 || t_rsp_timeout !== 1'b1 || t_rsp_rdata !== 8'h00 || t_m_enable !== 1'b0) begin
               bad++; $display("FAIL timeout_rsp: vld=%b to=%b rdata=%h en=%b want 0010 1 00 0",
                               t_rsp_valid, t_rsp_timeout, t_rsp_rdata, t_m_enable);
            end
         end
      end
      @(negedge clk);
      total++;
      if (t_busy !== 1'b0 || t_rsp_valid !== '0) begin bad++; $display("FAIL timeout_idle: busy=%b vld=%b want 0 0000", t_busy, t_rsp_valid); end
   endtask

   task automatic test_master_busy();
      rst = 1'b1; req_valid = '0; m_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      req_valid = 4'b0010; req_rw = '0;
      repeat (3) begin
         #1;
         total++;
         if (req_ready !== '0 || busy !== 1'b0) begin bad++; $display("FAIL busy_hold: rdy=%b busy=%b want 0000 0", req_ready, busy); end
         @(negedge clk);
      end
      m_ready = 1'b1;
      #1;
      total++;
      if (req_ready !== 4'b0010) begin bad++; $display("FAIL busy_grant: got %b want 0010", req_ready); end
      @(negedge clk);
      req_valid = '0; m_ready = 1'b0;
      @(negedge clk);
      m_ready = 1'b1;
      @(negedge clk);
      total++;
      if (rsp_valid !== 4'b0010 || rsp_timeout !== 1'b0) begin bad++; $display("FAIL busy_rsp: vld=%b to=%b want 0010 0", rsp_valid, rsp_timeout); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int pulses = 0;
      req_valid = 4'b1000; req_rw = 4'b1111;
      req_addr[3*AW +: AW] = 7'h11;
      #1;
      total++;
      if (req_ready !== 4'b1000) begin bad++; $display("FAIL mid_accept: got %b want 1000", req_ready); end
      @(negedge clk);
      req_valid = '0; m_ready = 1'b0;
      @(negedge clk);
      total++;
      if (busy !== 1'b1 || owner !== 2'd3 || m_enable !== 1'b0) begin
         bad++; $display("FAIL mid_wait: busy=%b owner=%0d en=%b want 1 3 0", busy, owner, m_enable);
      end
      rst = 1'b1;
      @(negedge clk);
      total++;
      if ({req_ready, rsp_valid, rsp_rdata, rsp_timeout, m_enable, m_rw, m_address, m_data_in, busy, owner} !== '0) begin
         bad++; $display("FAIL mid_reset_outputs: vld=%b en=%b busy=%b owner=%0d addr=%h rw=%b, required all zero",
                         rsp_valid, m_enable, busy, owner, m_address, m_rw);
      end
      rst = 1'b0; m_ready = 1'b1;
      repeat (3) begin
         @(negedge clk);
         if (rsp_valid !== '0) pulses++;
      end
      total++;
      if (pulses != 0) begin bad++; $display("FAIL mid_no_rsp: got %0d pulses want 0", pulses); end
      req_valid = 4'b1100; m_data_out = 8'h42;
      #1;
      total++;
      if (req_ready !== 4'b0100) begin bad++; $display("FAIL mid_ptr_reset: got %b want 0100", req_ready); end
      @(negedge clk);
      req_valid = '0; m_ready = 1'b0;
      @(negedge clk);
      m_ready = 1'b1;
      @(negedge clk);
      total++;
      if (rsp_valid !== 4'b0100 || rsp_rdata !== 8'h42 || rsp_timeout !== 1'b0) begin
         bad++; $display("FAIL mid_fresh_rsp: vld=%b rdata=%h to=%b want 0100 42 0", rsp_valid, rsp_rdata, rsp_timeout);
      end
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_write();
      test_read();
      test_contention();
      test_timeout();
      test_master_busy();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
